// File: rtl/layer_pkg.sv
// Shared types for the layer scheduler: FSM states, config field codes and
// the per-layer descriptor record.
package layer_pkg;

   // Descriptor fields are stored at this width; COORD_W may be narrower.
   localparam int MAX_COORD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      FLD_SRC_X    = 3'd0,
      FLD_SRC_Y    = 3'd1,
      FLD_WIDTH    = 3'd2,
      FLD_HEIGHT   = 3'd3,
      FLD_DST_X    = 3'd4,
      FLD_DST_Y    = 3'd5,
      FLD_LAYER_EN = 3'd6,
      FLD_CLR_ERR  = 3'd7
   } cfg_field_t;

   typedef logic [MAX_COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t src_x;
      coord_t src_y;
      coord_t w;
      coord_t h;
      coord_t dst_x;
      coord_t dst_y;
   } layer_desc_t;

endpackage

// File: rtl/layer_desc_table.sv
// Descriptor register file: one write port driven by the CPU config bus,
// combinational read of the entry selected by the scheduler index.
module layer_desc_table
   import layer_pkg::*;
#(
   parameter int NUM_LAYERS = 8,
   parameter int COORD_W    = 10,
   localparam int IDX_W     = $clog2(NUM_LAYERS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_we,
   input  logic [IDX_W-1:0]      i_idx,
   input  logic [2:0]            i_field,
   input  logic [COORD_W-1:0]    i_data,
   input  logic [IDX_W-1:0]      i_rd_idx,
   output layer_desc_t           o_desc,
   output logic                  o_en
);

   cfg_field_t               w_fld;
   coord_t                   w_val;
   layer_desc_t              w_tab [NUM_LAYERS];
   logic [NUM_LAYERS-1:0]    r_en;

   assign w_fld = cfg_field_t'(i_field);
   assign w_val = MAX_COORD_W'(i_data);

   for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_ent
      layer_desc_t r_ent;

      // Capture coordinate writes aimed at this entry
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_ent <= '0;
         end else if (i_we && (i_idx == IDX_W'(g))) begin
            case (w_fld)
               FLD_SRC_X:  r_ent.src_x <= w_val;
               FLD_SRC_Y:  r_ent.src_y <= w_val;
               FLD_WIDTH:  r_ent.w     <= w_val;
               FLD_HEIGHT: r_ent.h     <= w_val;
               FLD_DST_X:  r_ent.dst_x <= w_val;
               FLD_DST_Y:  r_ent.dst_y <= w_val;
               default:    ;
            endcase
         end
      end

      assign w_tab[g] = r_ent;
   end

   // Layer enable mask is global, written regardless of i_idx
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_en <= '0;
      else if (i_we && (w_fld == FLD_LAYER_EN))
         r_en <= i_data[NUM_LAYERS-1:0];
   end

   assign o_desc = w_tab[i_rd_idx];
   assign o_en   = r_en[i_rd_idx];

endmodule

// File: rtl/layer_scheduler.sv
// Per-frame layer sequencer: walks the descriptor table in index order and
// hands one blit command at a time to the draw engine, with a per-layer
// completion timeout and a single-deep pending-frame flag.
module layer_scheduler
   import layer_pkg::*;
#(
   parameter int NUM_LAYERS = 8,
   parameter int COORD_W    = 10,
   parameter int TIMEOUT    = 65535
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cfg_we,
   input  logic [$clog2(NUM_LAYERS)-1:0] cfg_idx,
   input  logic [2:0]                    cfg_field,
   input  logic [COORD_W-1:0]            cfg_data,
   input  logic                          frame_start,
   output logic                          blt_start,
   output logic [COORD_W-1:0]            blt_src_x,
   output logic [COORD_W-1:0]            blt_src_y,
   output logic [COORD_W-1:0]            blt_w,
   output logic [COORD_W-1:0]            blt_h,
   output logic [COORD_W-1:0]            blt_dst_x,
   output logic [COORD_W-1:0]            blt_dst_y,
   input  logic                          blt_done,
   output logic                          busy,
   output logic                          frame_done,
   output logic                          err,
   output logic [$clog2(NUM_LAYERS)-1:0] cur_layer
);

   localparam int IDX_W = $clog2(NUM_LAYERS);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t              r_state, w_nxt_state;
   logic [IDX_W-1:0]    r_idx, w_nxt_idx;
   logic [TMO_W-1:0]    r_tmo;
   logic                r_pend, r_err, r_busy, r_fdone, r_bstart;
   layer_desc_t         r_cmd;

   layer_desc_t         w_desc;
   logic                w_en, w_elig, w_last, w_tmo_hit;
   logic                w_clr_pend, w_set_err, w_clr_err;

   layer_desc_table #(
      .NUM_LAYERS (NUM_LAYERS),
      .COORD_W    (COORD_W)
   ) u_tab (
      .clk      (clk),
      .reset    (reset),
      .i_we     (cfg_we),
      .i_idx    (cfg_idx),
      .i_field  (cfg_field),
      .i_data   (cfg_data),
      .i_rd_idx (r_idx),
      .o_desc   (w_desc),
      .o_en     (w_en)
   );

   assign w_elig    = w_en && (w_desc.w != '0) && (w_desc.h != '0);
   assign w_last    = (r_idx == IDX_W'(NUM_LAYERS - 1));
   assign w_tmo_hit = (r_tmo == TMO_W'(1));
   assign w_clr_err = cfg_we && (cfg_field_t'(cfg_field) == FLD_CLR_ERR);

   // Next-state, index advance and side-effect strobes
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
      w_clr_pend  = 1'b0;
      w_set_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (frame_start) begin
               w_nxt_state = ST_SCAN;
               w_nxt_idx   = '0;
            end
         end
         ST_SCAN: begin
            if (w_elig)
               w_nxt_state = ST_ISSUE;
            else if (w_last)
               w_nxt_state = ST_DONE;
            else
               w_nxt_idx = r_idx + IDX_W'(1);
         end
         ST_ISSUE: w_nxt_state = ST_WAIT;
         ST_WAIT: begin
            if (blt_done || w_tmo_hit) begin
               // A completion arriving on the expiry cycle still counts as done
               w_set_err = !blt_done;
               if (w_last) begin
                  w_nxt_state = ST_DONE;
               end else begin
                  w_nxt_state = ST_SCAN;
                  w_nxt_idx   = r_idx + IDX_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (r_pend || frame_start) begin
               w_nxt_state = ST_SCAN;
               w_nxt_idx   = '0;
               w_clr_pend  = 1'b1;
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   // State, index and registered status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_busy   <= 1'b0;
         r_fdone  <= 1'b0;
         r_bstart <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_idx    <= w_nxt_idx;
         r_busy   <= (w_nxt_state != ST_IDLE);
         r_fdone  <= (w_nxt_state == ST_DONE);
         r_bstart <= (w_nxt_state == ST_ISSUE);
      end
   end

   // Command snapshot on entry to ISSUE; held until the next issue
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cmd <= '0;
      else if (w_nxt_state == ST_ISSUE)
         r_cmd <= w_desc;
   end

   // Timeout counter: armed with the command strobe, counts through ISSUE/WAIT
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_tmo <= '0;
      else if (w_nxt_state == ST_ISSUE)
         r_tmo <= TMO_W'(TIMEOUT);
      else if (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && (r_tmo != '0))
         r_tmo <= r_tmo - TMO_W'(1);
   end

   // Single-deep pending frame; extra starts while busy are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_pend <= 1'b0;
      else if (w_clr_pend)
         r_pend <= 1'b0;
      else if (frame_start && (r_state != ST_IDLE))
         r_pend <= 1'b1;
   end

   // Sticky error; a timeout in the same cycle as a clear wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_err <= 1'b0;
      else if (w_set_err)
         r_err <= 1'b1;
      else if (w_clr_err)
         r_err <= 1'b0;
   end

   assign blt_start  = r_bstart;
   assign blt_src_x  = COORD_W'(r_cmd.src_x);
   assign blt_src_y  = COORD_W'(r_cmd.src_y);
   assign blt_w      = COORD_W'(r_cmd.w);
   assign blt_h      = COORD_W'(r_cmd.h);
   assign blt_dst_x  = COORD_W'(r_cmd.dst_x);
   assign blt_dst_y  = COORD_W'(r_cmd.dst_y);
   assign busy       = r_busy;
   assign frame_done = r_fdone;
   assign err        = r_err;
   assign cur_layer  = r_idx;

endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Sequences the layer blitter once per frame. Holds a small table of layer descriptors: VRAM source rectangle plus framebuffer destination offset. On each frame trigger it walks the enabled layers in index order and issues one blit command per layer to the VRAM-reading draw engine, waiting for completion before issuing the next. It replaces hard-coded per-layer coordinates with a run-time programmable table and gives the CPU side a busy/done/error status.

## Interface
Parameters:
- NUM_LAYERS, 8, descriptor table depth (power of two, 2..16)
- COORD_W, 10, width of every coordinate/size field
- TIMEOUT, 65535, max cycles to wait for blt_done before aborting a layer

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- cfg_we  in  1  descriptor/register write strobe
- cfg_idx  in  $clog2(NUM_LAYERS)  layer index for descriptor writes
- cfg_field  in  3  0=src_x 1=src_y 2=width 3=height 4=dst_x 5=dst_y 6=layer_en mask 7=clear err
- cfg_data  in  COORD_W  write data; field 6 uses cfg_data[NUM_LAYERS-1:0] (NUM_LAYERS ≤ COORD_W)
- frame_start  in  1  pulse: run one pass over the table
- blt_start  out  1  one-cycle command strobe to blitter
- blt_src_x, blt_src_y, blt_w, blt_h, blt_dst_x, blt_dst_y  out  COORD_W each  command fields
- blt_done  in  1  blitter completion pulse
- busy  out  1  pass in progress
- frame_done  out  1  one-cycle pulse at end of pass
- err  out  1  sticky timeout flag
- cur_layer  out  $clog2(NUM_LAYERS)  index being scanned/issued

## Operation
- States: IDLE, SCAN, ISSUE, WAIT, DONE.
- IDLE: on frame_start, go to SCAN with idx=0.
- SCAN: layer idx is eligible when layer_en[idx]=1 and width≠0 and height≠0.
  - Eligible: go to ISSUE.
  - Not eligible and idx=NUM_LAYERS-1: go to DONE.
  - Otherwise: idx+1, stay in SCAN.
- ISSUE: snapshot the descriptor into the blt_* registers, pulse blt_start, go to WAIT, load the timeout counter.
- WAIT: on blt_done, or on timeout expiry (timeout also sets err):
  - If idx=NUM_LAYERS-1: go to DONE.
  - Otherwise: idx+1, go to SCAN.
- DONE: pulse frame_done. Go to SCAN with idx=0 if a frame is pending, else to IDLE.
- frame_start while busy sets a single pending flag; further starts are dropped. The flag clears when the new pass begins.
- blt_done outside WAIT is ignored.
- Config writes are accepted in any state, including for the layer currently in WAIT. They take effect at that layer's next ISSUE.
- Field 7 write clears err. err set and clear in the same cycle: set wins.
- Arithmetic: idx wraps are impossible by construction. Descriptor fields are passed through unmodified; there is no clipping (blitter's job).
- Reset mid-pass: everything returns to reset values immediately. A blitter command already in progress is abandoned (its later blt_done is ignored in IDLE).

## Timing
- Reset values:
  - Outputs: blt_start=0, busy=0, frame_done=0, err=0, cur_layer=0, all blt_* fields=0.
  - Table: all descriptors 0, layer_en=0.
- All outputs are registered.
- frame_start sampled at edge N with layer 0 eligible: blt_start high during cycle N+2, busy high from N+1.
- Each ineligible layer adds 1 SCAN cycle.
- blt_* fields stable from blt_start until the next ISSUE.
- blt_done sampled at edge M: next blt_start no earlier than M+2. If it was the last layer, frame_done high during M+1 and busy low from M+2 unless a frame is pending.
- Timeout: err set and layer aborted TIMEOUT cycles after blt_start with no blt_done.
- Write in cycle K is visible to a SCAN/ISSUE at K+1.

## Structure
- Shared package (layer_pkg):
  - state enum
  - cfg_field codes (FLD_SRC_X…FLD_CLR_ERR)
  - descriptor struct {src_x, src_y, w, h, dst_x, dst_y}
- One sub-module, layer_desc_table: register-file descriptor storage with write port and async read by idx, plus the layer_en register.
- FSM, timeout counter and pending flag live in layer_scheduler.

## Test plan
- Program L0={1,1,160,120,0,0}, L1={40,240,40,33,87,57}, en=0b011. Pulse frame_start; blitter model acks 5 cycles after each start -> exactly two blt_start with those exact fields, in order, then one frame_done; busy low afterward.
- en=0b10000001 (layers 0, 7) with L3 w=0 -> blt_start only for 0 and 7; scan of 1..6 costs 6 cycles; frame_done once.
- frame_start pulsed 3 times during a pass -> exactly one extra pass follows immediately; total frame_done count=2.
- Blitter model never acks, TIMEOUT=20 -> err=1 at start+20; next enabled layer still issued; frame_done occurs; field-7 write clears err.
- Reset asserted while in WAIT -> all outputs 0 asynchronously; late blt_done ignored; next frame_start runs normally.
- Rewrite L1 dst_x=99 while L1 is in WAIT -> current command unchanged; next pass issues dst_x=99.
